// File: rtl/clipper_timebase.sv
// clipper_timebase: free-running seconds/nanoseconds time-of-day with load, freeze, accelerate and 1PPS
module clipper_timebase #(
  parameter int G_INC_NS = 8,
  parameter int G_INC_FRAC = 0,
  parameter int G_ACCEL_MULT = 1000,
  parameter int G_PPS_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timebase_force,
  input  logic        timebase_accelerate,
  input  logic [63:0] timebase_time,
  input  logic        freeze,
  output logic [63:0] time_out,
  output logic        time_valid,
  output logic        sec_tick,
  output logic        pps,
  output logic        load_done,
  output logic        load_err
);
  localparam logic [31:0] ns_per_sec = 32'd1_000_000_000;
  localparam int pw = $clog2(G_PPS_WIDTH + 1);
  localparam logic [63:0] acc_prod = 64'(G_INC_FRAC) * 64'(G_ACCEL_MULT);
  // integer part of the multiplied fraction folds into the accelerated ns step
  localparam logic [31:0] step_ns_acc = 32'(G_INC_NS * G_ACCEL_MULT) + 32'(acc_prod >> 16);
  localparam logic [31:0] step_ns_nom = 32'(G_INC_NS);
  localparam logic [15:0] step_frac_acc = acc_prod[15:0];
  localparam logic [15:0] step_frac_nom = 16'(G_INC_FRAC);
  logic [31:0] sec, ns, ns_sum, ld_ns;
  logic [15:0] frac;
  logic [16:0] frac_sum;
  logic [pw-1:0] pps_cnt;
  logic force_q, wrap, cnt_en;
  always_comb begin
    frac_sum = {1'b0, frac} + {1'b0, timebase_accelerate ? step_frac_acc : step_frac_nom};
    ns_sum = ns + (timebase_accelerate ? step_ns_acc : step_ns_nom) + {31'd0, frac_sum[16]};
    wrap = ns_sum >= ns_per_sec;
    cnt_en = !timebase_force && !freeze;
    ld_ns = timebase_time[31:0] >= ns_per_sec ? ns_per_sec - 32'd1 : timebase_time[31:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec <= '0;
      ns <= '0;
      frac <= '0;
      time_valid <= 1'b0;
      sec_tick <= 1'b0;
      pps_cnt <= '0;
      force_q <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      force_q <= timebase_force;
      load_done <= timebase_force && !force_q;
      load_err <= timebase_force && !force_q && timebase_time[31:0] >= ns_per_sec;
      sec_tick <= cnt_en && wrap;
      pps_cnt <= cnt_en && wrap ? pw'(G_PPS_WIDTH) : pps_cnt != '0 ? pps_cnt - pw'(1) : '0;
      if (timebase_force) begin
        sec <= timebase_time[63:32];
        ns <= ld_ns;
        frac <= '0;
        time_valid <= 1'b1;
      end else if (!freeze) begin
        frac <= frac_sum[15:0];
        ns <= wrap ? ns_sum - ns_per_sec : ns_sum;
        sec <= sec + 32'(wrap);
      end
    end
  end
  assign time_out = {sec, ns};
  assign pps = pps_cnt != '0;
endmodule

// File: tb/tb_clipper_timebase.sv
// tb_clipper_timebase: directed checks of load, count, wrap, accelerate, fraction, freeze, pps and reset
module tb_clipper_timebase;
  logic clk = 1'b0;
  logic rst_n, tforce, accel, freeze;
  logic [63:0] ttime;
  logic [63:0] time_out, time_out2;
  logic time_valid, sec_tick, pps, load_done, load_err;
  logic time_valid2, sec_tick2, pps2, load_done2, load_err2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clipper_timebase dut (
    .clk(clk), .rst_n(rst_n), .timebase_force(tforce), .timebase_accelerate(accel),
    .timebase_time(ttime), .freeze(freeze), .time_out(time_out), .time_valid(time_valid),
    .sec_tick(sec_tick), .pps(pps), .load_done(load_done), .load_err(load_err)
  );

  clipper_timebase #(.G_INC_FRAC(16'h8000)) dut_frac (
    .clk(clk), .rst_n(rst_n), .timebase_force(tforce), .timebase_accelerate(accel),
    .timebase_time(ttime), .freeze(freeze), .time_out(time_out2), .time_valid(time_valid2),
    .sec_tick(sec_tick2), .pps(pps2), .load_done(load_done2), .load_err(load_err2)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk(tag, {59'd0, time_valid, sec_tick, pps, load_done, load_err}, {59'd0, exp});
  endtask

  task automatic load(input logic [63:0] t);
    tforce = 1'b1;
    ttime = t;
    tick();
    tforce = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tforce = 1'b0; accel = 1'b0; freeze = 1'b0; ttime = '0;
    tick(2);
    chk("reset_time", time_out, 64'd0);
    chk_flags("reset_flags", 5'b00000);
    rst_n = 1'b1;
    tick(10);
    chk("count10_time", time_out, 64'h50);
    chk_flags("count10_flags", 5'b00000);
    chk("count10_frac_time", time_out2, 64'd85);
    load(64'h0000_0005_3B9A_C9F0);
    chk("force_time", time_out, 64'h0000_0005_3B9A_C9F0);
    chk_flags("force_flags", 5'b10010);
    tick();
    chk("pre_wrap_time", time_out, {32'd5, 32'd999_999_992});
    chk_flags("pre_wrap_flags", 5'b10000);
    tick();
    chk("wrap_time", time_out, 64'h0000_0006_0000_0000);
    chk_flags("wrap_flags", 5'b11100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pps_hold", {62'd0, sec_tick, pps}, 64'b01);
    end
    tick();
    chk("pps_end", {63'd0, pps}, 64'd0);
    load(64'd0);
    accel = 1'b1;
    tick(3);
    chk("accel3", time_out, 64'd24_000);
    accel = 1'b0;
    tick();
    chk("accel_off", time_out, 64'd24_008);
    load(64'd0);
    tick(4);
    chk("frac4", time_out2, 64'd34);
    chk("nofrac4", time_out, 64'd32);
    load(64'd0);
    accel = 1'b1;
    tick();
    chk("frac_accel", time_out2, 64'd8500);
    chk("nofrac_accel", time_out, 64'd8000);
    accel = 1'b0;
    load({32'd5, 32'd999_999_992});
    tick();
    chk("wrap2_time", time_out, 64'h0000_0006_0000_0000);
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("freeze_time", time_out, 64'h0000_0006_0000_0000);
      chk("freeze_pps", {62'd0, sec_tick, pps}, {62'd0, 1'b0, i < 3});
    end
    load(64'h0000_000A_0000_0064);
    chk("freeze_force_time", time_out, 64'h0000_000A_0000_0064);
    chk_flags("freeze_force_flags", 5'b10010);
    tick();
    chk("freeze_after_force", time_out, 64'h0000_000A_0000_0064);
    freeze = 1'b0;
    tick();
    chk("unfreeze", time_out, 64'h0000_000A_0000_006C);
    tforce = 1'b1;
    ttime = {32'd3, 32'd1_000_000_000};
    tick();
    chk("clamp_time", time_out, {32'd3, 32'd999_999_999});
    chk_flags("clamp_flags", 5'b10011);
    tick();
    chk("force_held_time", time_out, {32'd3, 32'd999_999_999});
    chk_flags("force_held_flags", 5'b10000);
    tforce = 1'b0;
    tick();
    chk("clamp_wrap", time_out, {32'd4, 32'd7});
    chk_flags("clamp_wrap_flags", 5'b11100);
    load({32'd7, 32'd100});
    chk("force_in_pps", time_out, {32'd7, 32'd100});
    chk_flags("force_in_pps_flags", 5'b10110);
    tforce = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("rst_time", time_out, 64'd0);
    chk_flags("rst_flags", 5'b00000);
    rst_n = 1'b1;
    tick();
    chk("force_across_rst", time_out, {32'd7, 32'd100});
    chk_flags("force_across_rst_flags", 5'b10010);
    tforce = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
